// File: rtl/accel_pkg.sv
// Shared definitions for the AI accelerator Wishbone window and its host master:
// window base, register map, opcodes and the master FSM state encoding.
package accel_pkg;

    localparam logic [31:0] ACCEL_ADDR_OFFSET = 32'h3000_0000;

    // Register map inside the window (byte offsets)
    localparam logic [31:0] REG_OPERATION = 32'h0000_0000;
    localparam logic [31:0] REG_STATUS    = 32'h0000_0004;
    localparam logic [31:0] SRAM_BASE     = 32'h0000_0008;

    // Operation codes and the status value that kicks off an operation
    localparam logic [31:0] OP_MMUL       = 32'd1;
    localparam logic [31:0] OP_MCONV      = 32'd2;
    localparam logic [31:0] STATUS_START  = 32'hFFFF_FFFF;

    // The master always transfers whole words
    localparam logic [3:0]  WB_SEL_ALL    = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_BUS   = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } mst_state_e;

    // Byte offset of the following word; wraps modulo 2^32
    function automatic logic [31:0] next_word_off(input logic [31:0] off);
        return off + 32'd4;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Bus-cycle watchdog: cleared by load, counts while en is high, and flags
// expire once LIMIT counted cycles have elapsed (expire is high during the
// LIMIT-th cycle so the owner can abort on that edge).
module wb_timeout_ctr #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int unsigned CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == LAST);

    // Next count: restart on load, saturate at the expiry value
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (en && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_accel_host_master.sv
// Wishbone classic initiator for the accelerator window. Runs block commands
// of N single-word reads or writes at consecutive word addresses, one bus
// cycle at a time, with a mandatory idle cycle between words so the slave can
// re-arm after its ack drops. Write data arrives and read data leaves on
// valid/ready streams.
// Optional feature: define WB_TIMEOUT_EN to abort a bus cycle that is not
// acknowledged within TIMEOUT_CYC cycles (sets the sticky err flag).
module wb_accel_host_master
    import accel_pkg::*;
#(
    parameter logic [31:0] ADDR_OFFSET = ACCEL_ADDR_OFFSET,
    parameter int unsigned LEN_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    // command
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    // write data stream
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    // read data stream
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    // status
    output logic             done,
    output logic             err,
    // Wishbone initiator
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    mst_state_e       state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      off_q, off_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [31:0]      dat_q, dat_d;
    logic [31:0]      rd_q, rd_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             bus_timeout;

    // The two low address bits are ignored (word aligned); TIMEOUT_CYC only
    // matters when the watchdog is built in.
    logic unused_cfg;
    assign unused_cfg = ^{cmd_addr[1:0], TIMEOUT_CYC};

`ifdef WB_TIMEOUT_EN
    logic tmo_load;
    logic tmo_expire;

    // Restart the watchdog on every entry into BUS
    assign tmo_load = (state_d == ST_BUS) && (state_q != ST_BUS);

    wb_timeout_ctr #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .load   (tmo_load),
        .en     (state_q == ST_BUS),
        .expire (tmo_expire)
    );

    assign bus_timeout = tmo_expire;
`else
    assign bus_timeout = 1'b0;
`endif

    // Stream handshakes and bus outputs decode straight from the state flop
    assign cmd_ready = (state_q == ST_IDLE);
    assign wr_ready  = (state_q == ST_FETCH);
    assign rd_valid  = (state_q == ST_RESP);
    assign rd_data   = rd_q;
    assign done      = done_q;
    assign err       = err_q;

    assign wbm_cyc_o = (state_q == ST_BUS);
    assign wbm_stb_o = wbm_cyc_o;
    assign wbm_we_o  = wbm_cyc_o & we_q;
    assign wbm_sel_o = WB_SEL_ALL;
    assign wbm_adr_o = wbm_cyc_o ? (ADDR_OFFSET + off_q) : 32'h0;
    assign wbm_dat_o = dat_q;

    // Next-state and datapath updates; done is a registered single-cycle pulse
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        rd_d    = rd_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    we_d  = cmd_we;
                    off_d = {cmd_addr[31:2], 2'b00};
                    cnt_d = cmd_len;
                    err_d = 1'b0;
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = cmd_we ? ST_FETCH : ST_BUS;
                    end
                end
            end
            ST_FETCH: begin
                if (wr_valid) begin
                    dat_d   = wr_data;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                // An ack on the expiry cycle still completes the word
                if (wbm_ack_i) begin
                    if (we_q) begin
                        state_d = ST_GAP;
                    end else begin
                        rd_d    = wbm_dat_i;
                        state_d = ST_RESP;
                    end
                end else if (bus_timeout) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RESP: begin
                if (rd_ready) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q - 1'b1;
                off_d = next_word_off(off_q);
                if (cnt_q == LEN_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = we_q ? ST_FETCH : ST_BUS;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset releases the bus at once
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            off_q   <= 32'h0;
            cnt_q   <= '0;
            dat_q   <= 32'h0;
            rd_q    <= 32'h0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_accel_host_master.sv
// Directed bench for wb_accel_host_master: a word-memory slave BFM with
// adjustable ack latency, a write-data feeder, a bus monitor and
// hand-computed expectations for each command scenario.
module tb_wb_accel_host_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = 32'h0;
    logic [7:0]  cmd_len = 8'h0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_data = 32'h0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [31:0] rd_data;
    logic        done;
    logic        err;
    logic        cyc, stb, we, ack;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;

    always #5 clk = ~clk;

    wb_accel_host_master dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .wbm_cyc_o (cyc),
        .wbm_stb_o (stb),
        .wbm_we_o  (we),
        .wbm_sel_o (sel),
        .wbm_adr_o (adr),
        .wbm_dat_o (dat_o),
        .wbm_dat_i (dat_i),
        .wbm_ack_i (ack)
    );

    int n_run = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Slave BFM: word memory, ack after lat+1 strobed cycles, re-arms when cyc drops
    logic [31:0] mem [0:15];
    int lat = 3;
    bit no_ack = 1'b0;
    int wcnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack   <= 1'b0;
            dat_i <= 32'h0;
            wcnt  <= 0;
        end else begin
            ack <= 1'b0;
            if (cyc && stb && !ack && !no_ack) begin
                if (wcnt >= lat) begin
                    ack  <= 1'b1;
                    wcnt <= 0;
                    if (we) mem[adr[5:2]] <= dat_o;
                    else    dat_i <= mem[adr[5:2]];
                end else begin
                    wcnt <= wcnt + 1;
                end
            end else if (!cyc) begin
                wcnt <= 0;
            end
        end
    end

    // Monitor sampled on the falling edge
    int done_cnt = 0, rise_cnt = 0, cyc_hi = 0, rv_cnt = 0, low_run = 0;
    int bad_stb = 0, bad_sel = 0;
    logic prev_cyc = 1'b0;
    bit wfire = 1'b0;
    logic [31:0] adr_log[$];
    logic        we_log[$];
    int          gap_log[$];
    logic [31:0] rd_got[$];
    logic [31:0] wq[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rd_valid) rv_cnt++;
        if (stb !== cyc) bad_stb++;
        if (sel !== 4'hF) bad_sel++;
        if (cyc) cyc_hi++;
        if (cyc && !prev_cyc) begin
            rise_cnt++;
            adr_log.push_back(adr);
            we_log.push_back(we);
            gap_log.push_back(low_run);
        end
        low_run  = cyc ? 0 : low_run + 1;
        prev_cyc = cyc;
        if (rd_valid && rd_ready) rd_got.push_back(rd_data);
        wfire = wr_valid && wr_ready;
    end

    // Write-data feeder driven from wq
    initial forever begin
        @(posedge clk);
        #1;
        if (wfire && wq.size() != 0) void'(wq.pop_front());
        wr_valid = (wq.size() != 0);
        wr_data  = (wq.size() != 0) ? wq[0] : 32'h0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        adr_log.delete();
        we_log.delete();
        gap_log.delete();
        rd_got.delete();
        rise_cnt = 0;
        cyc_hi   = 0;
        rv_cnt   = 0;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] n);
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_we    = w;
        cmd_addr  = a;
        cmd_len   = n;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int base);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            tick(1);
            k++;
        end
        if (done_cnt == base) chk("done_wait_expired", 32'h0, 32'h1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int base;
        int k;
        logic [31:0] held;

        // Reset state
        tick(2);
        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_cyc", {31'h0, cyc}, 32'h0);
        chk("rst_stb", {31'h0, stb}, 32'h0);
        chk("rst_we", {31'h0, we}, 32'h0);
        chk("rst_sel", {28'h0, sel}, 32'hF);
        chk("rst_adr", adr, 32'h0);
        chk("rst_dat_o", dat_o, 32'h0);
        chk("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        tick(2);

        // 1: single write to the operation register
        clr();
        base = done_cnt;
        wq.push_back(32'd1);
        issue(1'b1, 32'h0, 8'd1);
        wait_done(100, base);
        tick(2);
        chk("t1_cycles", rise_cnt, 1);
        chk("t1_adr", adr_log[0], BASE);
        chk("t1_we", {31'h0, we_log[0]}, 32'h1);
        chk("t1_mem", mem[0], 32'd1);
        chk("t1_done_pulses", done_cnt - base, 1);

        // 2: four-word write then read back
        clr();
        base = done_cnt;
        wq.push_back(32'd10); wq.push_back(32'd20); wq.push_back(32'd30); wq.push_back(32'd40);
        issue(1'b1, 32'h8, 8'd4);
        wait_done(200, base);
        tick(2);
        chk("t2w_cycles", rise_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2w_adr", adr_log[i], BASE + 32'h8 + 32'(4 * i));
            chk("t2w_mem", mem[2 + i], 32'(10 * (i + 1)));
        end
        for (int i = 1; i < 4; i++) chk("t2w_gap", gap_log[i], 2);
        clr();
        base = done_cnt;
        rd_ready = 1'b1;
        issue(1'b0, 32'h8, 8'd4);
        wait_done(200, base);
        tick(2);
        chk("t2r_cycles", rise_cnt, 4);
        chk("t2r_count", rd_got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("t2r_adr", adr_log[i], BASE + 32'h8 + 32'(4 * i));
            chk("t2r_we", {31'h0, we_log[i]}, 32'h0);
            chk("t2r_data", rd_got[i], 32'(10 * (i + 1)));
        end
        for (int i = 1; i < 4; i++) chk("t2r_gap", gap_log[i], 2);

        // 3: read with back-pressure on the read stream
        clr();
        base = done_cnt;
        rd_ready = 1'b0;
        issue(1'b0, 32'h8, 8'd2);
        k = 0;
        while (!rd_valid && k < 100) begin tick(1); k++; end
        chk("t3_rd_valid_seen", {31'h0, rd_valid}, 32'h1);
        held = rd_data;
        chk("t3_first", held, 32'd10);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("t3_hold_valid", {31'h0, rd_valid}, 32'h1);
            chk("t3_hold_data", rd_data, 32'd10);
            chk("t3_hold_cyc", {31'h0, cyc}, 32'h0);
        end
        rd_ready = 1'b1;
        wait_done(200, base);
        tick(2);
        chk("t3_cycles", rise_cnt, 2);
        chk("t3_count", rd_got.size(), 2);
        chk("t3_data0", rd_got[0], 32'd10);
        chk("t3_data1", rd_got[1], 32'd20);
        chk("t3_gap_after_hold", {31'h0, gap_log[1] >= 6}, 32'h1);

        // 4: zero-length command
        clr();
        base = done_cnt;
        issue(1'b0, 32'h10, 8'd0);
        chk("t4_done_now", {31'h0, done}, 32'h1);
        chk("t4_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        tick(3);
        chk("t4_done_pulses", done_cnt - base, 1);
        chk("t4_no_cycle", rise_cnt, 0);

`ifdef WB_TIMEOUT_EN
        // 5: slave never acks
        clr();
        base = done_cnt;
        no_ack = 1'b1;
        issue(1'b0, 32'h8, 8'd3);
        wait_done(300, base);
        tick(2);
        chk("t5_bus_cycles", cyc_hi, 64);
        chk("t5_err", {31'h0, err}, 32'h1);
        chk("t5_no_rd_valid", rv_cnt, 0);
        chk("t5_one_cycle", rise_cnt, 1);
        chk("t5_done_pulses", done_cnt - base, 1);
        no_ack = 1'b0;
        issue(1'b0, 32'h8, 8'd0);
        chk("t5_err_cleared", {31'h0, err}, 32'h0);
        tick(2);
`else
        // 5: slow slave; the master waits without limit
        clr();
        base = done_cnt;
        lat = 100;
        issue(1'b0, 32'h8, 8'd1);
        wait_done(400, base);
        tick(2);
        chk("t5_bus_cycles", cyc_hi, 102);
        chk("t5_data", rd_got[0], 32'd10);
        chk("t5_err", {31'h0, err}, 32'h0);
        lat = 3;
`endif

        // 6: reset in the middle of a bus cycle
        clr();
        base = done_cnt;
        lat = 10;
        wq.push_back(32'd1); wq.push_back(32'd2); wq.push_back(32'd3); wq.push_back(32'd4);
        issue(1'b1, 32'h20, 8'd4);
        k = 0;
        while (!cyc && k < 50) begin tick(1); k++; end
        chk("t6_in_bus", {31'h0, cyc}, 32'h1);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cyc", {31'h0, cyc}, 32'h0);
        chk("t6_rst_stb", {31'h0, stb}, 32'h0);
        chk("t6_rst_done", {31'h0, done}, 32'h0);
        chk("t6_rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        wq.delete();
        tick(3);
        rst_n = 1'b1;
        lat = 3;
        tick(2);
        chk("t6_no_done", done_cnt - base, 0);
        chk("t6_aborted_cycles", rise_cnt, 1);
        clr();
        base = done_cnt;
        wq.push_back(32'd77);
        issue(1'b1, 32'h24, 8'd1);
        wait_done(100, base);
        tick(2);
        chk("t6_fresh_adr", adr_log[0], BASE + 32'h24);
        chk("t6_fresh_mem", mem[9], 32'd77);
        clr();
        base = done_cnt;
        issue(1'b0, 32'h24, 8'd1);
        wait_done(100, base);
        tick(2);
        chk("t6_readback", rd_got[0], 32'd77);

        chk("stb_equals_cyc", bad_stb, 0);
        chk("sel_constant", bad_sel, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
